// File: rtl/silife_pkg.sv
// Shared types and helpers for the SiLife demo sequencer.
package silife_pkg;

  // Sequencer phases: load the grid row by row, then run generation steps.
  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } silife_state_e;

  // Suggested step period for a free-running demo on a ~MHz-class clock.
  localparam int DEFAULT_PERIOD = 4_000_000;

  // Number of distinct built-in pattern shapes; larger ROMs repeat them.
  localparam int NUM_PATTERN_KINDS = 4;

  // Width of a pattern index; never narrower than one bit.
  function automatic int pat_width(input int num_patterns);
    return (num_patterns <= 1) ? 1 : $clog2(num_patterns);
  endfunction

  // Width of a row index.
  function automatic int row_width(input int rows);
    return (rows <= 1) ? 1 : $clog2(rows);
  endfunction

endpackage

// File: rtl/silife_pattern_rom.sv
// Combinational pattern ROM. Each ROM row is a COLS-bit word whose MSB is
// grid column 0; the output is reordered so data[c] is column c.
// Shapes (ROM word view): 0 = glider in the top-left corner,
// 1 = checkerboard, 2 = diagonal line, 3 = row-number hash.
module silife_pattern_rom
  import silife_pkg::*;
#(
  parameter int ROWS         = 32,
  parameter int COLS         = 8,
  parameter int NUM_PATTERNS = 4,
  localparam int ROW_W       = row_width(ROWS),
  localparam int PAT_W       = pat_width(NUM_PATTERNS)
) (
  input  logic [PAT_W-1:0] pat,
  input  logic [ROW_W-1:0] row,
  output logic [COLS-1:0]  data
);

  logic [1:0]      w_kind;
  logic [31:0]     w_row32;
  logic [COLS-1:0] w_hash;
  logic [COLS-1:0] w_word;

  assign w_kind  = 2'(int'(pat) % NUM_PATTERN_KINDS);
  assign w_row32 = 32'(row);
  assign w_hash  = COLS'(w_row32 * 32'd37 + 32'd11);

  // Build the ROM word for the selected shape and row.
  always_comb begin
    w_word = '0;
    case (w_kind)
      2'd0: begin
        if (w_row32 == 32'd0)      w_word[COLS-2] = 1'b1;
        else if (w_row32 == 32'd1) w_word[COLS-3] = 1'b1;
        else if (w_row32 == 32'd2) w_word[COLS-1 -: 3] = 3'b111;
      end
      2'd1: begin
        for (int b = 0; b < COLS; b++) w_word[b] = (b % 2 == 1) ^ w_row32[0];
      end
      2'd2: begin
        for (int b = 0; b < COLS; b++) w_word[b] = (32'(COLS - 1 - b) == (w_row32 % 32'(COLS)));
      end
      default: begin
        w_word = w_hash;
      end
    endcase
  end

  // ROM word MSB lands on column 0.
  always_comb begin
    data = '0;
    for (int c = 0; c < COLS; c++) data[c] = w_word[COLS-1-c];
  end

endmodule

// File: rtl/silife_demo_seq.sv
// Demo sequencer for the SiLife cell array: loads a ROM pattern into the
// grid one row per cycle, then issues periodic or single generation steps.
//
// Requests: load and single_step are single-cycle pulses sampled on an
// enabled clock edge; nothing is queued, a request seen while en=0 is lost.
// load has priority over any step in the same cycle.
module silife_demo_seq
  import silife_pkg::*;
#(
  parameter int ROWS         = 32,
  parameter int COLS         = 8,
  parameter int NUM_PATTERNS = 4,
  parameter int CNT_W        = 32,
  localparam int ROW_W       = row_width(ROWS),
  localparam int PAT_W       = pat_width(NUM_PATTERNS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PAT_W-1:0] pattern_sel,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic             pause,
  input  logic             single_step,
  output logic [ROW_W-1:0] row_select,
  output logic [COLS-1:0]  cells,
  output logic             wr_en,
  output logic             step,
  output logic             busy,
  output silife_state_e    dbg_state
);

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE   = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PAT_W:0]   NUM_PAT_L = NUM_PATTERNS[PAT_W:0];

  silife_state_e    r_state;
  logic [ROW_W-1:0] r_row;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wr_en;
  logic             r_step;
  logic [PAT_W-1:0] w_sel_norm;

  // Out-of-range selections fall back to pattern 0.
  assign w_sel_norm = ({1'b0, pattern_sel} >= NUM_PAT_L) ? '0 : pattern_sel;

  // Sequencer FSM with row counter, step counter and request arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_row   <= '0;
      r_wr_en <= 1'b0;
      r_step  <= 1'b0;
      r_cnt   <= '0;
      r_pat   <= w_sel_norm;
    end else if (!en) begin
      // Freeze; strobes drop so resuming a load repeats the setup cycle.
      r_wr_en <= 1'b0;
      r_step  <= 1'b0;
    end else if (load) begin
      r_state <= ST_LOAD;
      r_pat   <= w_sel_norm;
      r_row   <= '0;
      r_wr_en <= 1'b0;
      r_step  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_step <= 1'b0;
          if (!r_wr_en) begin
            r_wr_en <= 1'b1;
          end else if (r_row == ROW_LAST) begin
            r_wr_en <= 1'b0;
            r_row   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_row <= r_row + ROW_ONE;
          end
        end
        ST_RUN: begin
          r_wr_en <= 1'b0;
          if (pause) begin
            r_step <= single_step;
          end else if (period == '0) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
          end else if (r_cnt >= period - CNT_ONE) begin
            // >= also catches a period shrunk below the running count.
            r_cnt  <= '0;
            r_step <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_step <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_LOAD;
          r_row   <= '0;
          r_wr_en <= 1'b0;
          r_step  <= 1'b0;
        end
      endcase
    end
  end

  silife_pattern_rom #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .NUM_PATTERNS(NUM_PATTERNS)
  ) u_rom (
    .pat (r_pat),
    .row (r_row),
    .data(cells)
  );

  assign row_select = r_row;
  assign wr_en      = r_wr_en;
  assign step       = r_step;
  assign busy       = (r_state == ST_LOAD);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_silife_demo_seq.sv
// Bench for silife_demo_seq: directed scenarios plus a randomized run,
// all compared cycle by cycle against a behavioural model.
module tb_silife_demo_seq;
  import silife_pkg::*;

  localparam int ROWS         = 32;
  localparam int COLS         = 8;
  localparam int NUM_PATTERNS = 4;
  localparam int CNT_W        = 32;
  localparam int ROW_W        = 5;
  localparam int PAT_W        = 2;
  localparam int OBS_W        = 3 + ROW_W + COLS;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n, en, load, pause, single_step;
  logic [PAT_W-1:0] pattern_sel;
  logic [CNT_W-1:0] period;
  logic [ROW_W-1:0] row_select;
  logic [COLS-1:0]  cells;
  logic             wr_en, step, busy;
  silife_state_e    dbg_state;
  logic [OBS_W-1:0] w_obs;

  always #5 clk = ~clk;

  silife_demo_seq #(
    .ROWS(ROWS), .COLS(COLS), .NUM_PATTERNS(NUM_PATTERNS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel), .load(load),
    .period(period), .pause(pause), .single_step(single_step),
    .row_select(row_select), .cells(cells), .wr_en(wr_en), .step(step),
    .busy(busy), .dbg_state(dbg_state)
  );

  assign w_obs = {busy, wr_en, step, row_select, cells};

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  // Loading: setup cycle, then one row per enabled cycle. Running: a step
  // once 'period' unpaused enabled cycles have elapsed since the last one.
  bit m_loading, m_wr, m_step;
  int m_row, m_pat, m_since;
  int wr_cnt[ROWS];

  function automatic int norm_sel(input int s);
    return (s >= NUM_PATTERNS) ? 0 : s;
  endfunction

  // Grid columns for pattern p, row r (column c is bit c).
  function automatic logic [COLS-1:0] exp_cells(input int p, input int r);
    logic [COLS-1:0] c;
    logic [7:0]      v;
    c = '0;
    case (p % 4)
      0: begin
        if (r == 0)      c[1] = 1'b1;
        else if (r == 1) c[2] = 1'b1;
        else if (r == 2) c[2:0] = 3'b111;
      end
      1: for (int i = 0; i < COLS; i++) c[i] = ((i + r) % 2 == 0);
      2: c[r % COLS] = 1'b1;
      default: begin
        v = 8'((r * 37 + 11) & 255);
        for (int i = 0; i < COLS; i++) c[i] = v[7 - i];
      end
    endcase
    return c;
  endfunction

  function automatic logic [OBS_W-1:0] exp_vec();
    return {m_loading, m_wr, m_step, ROW_W'(m_row), exp_cells(m_pat, m_row)};
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_loading = 1; m_row = 0; m_wr = 0; m_step = 0; m_since = 0;
      m_pat = norm_sel(int'(pattern_sel));
    end else if (!en) begin
      m_wr = 0; m_step = 0;
    end else if (load) begin
      m_loading = 1; m_row = 0; m_wr = 0; m_step = 0; m_since = 0;
      m_pat = norm_sel(int'(pattern_sel));
    end else if (m_loading) begin
      m_step = 0;
      if (!m_wr) m_wr = 1;
      else if (m_row == ROWS - 1) begin m_wr = 0; m_row = 0; m_loading = 0; end
      else m_row++;
    end else begin
      if (pause) m_step = single_step;
      else if (period == 0) begin m_since = 0; m_step = 0; end
      else begin
        m_since++;
        if (m_since >= int'(period)) begin m_step = 1; m_since = 0; end
        else m_step = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock: count the row write taken at this edge, advance the model,
  // then settle past the edge so outputs can be sampled.
  task automatic tick();
    if (rst_n && en && !load && wr_en === 1'b1) wr_cnt[row_select]++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_wr_cnt();
    for (int r = 0; r < ROWS; r++) wr_cnt[r] = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; en = 1; pattern_sel = 1; load = 0; pause = 0; single_step = 0; period = 5;
    clear_wr_cnt();
    repeat (3) tick();
    n_checks++;
    if (w_obs !== exp_vec()) $display("FAIL reset_vec: got %h required %h", w_obs, exp_vec());
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || wr_en !== 1'b0 || step !== 1'b0 || row_select !== '0)
      $display("FAIL reset_outputs: busy=%b wr_en=%b step=%b row=%0d required 1 0 0 0",
               busy, wr_en, step, row_select);
    else n_pass++;
    n_checks++;
    if (dbg_state !== ST_LOAD) $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_LOAD);
    else n_pass++;
  endtask

  task automatic test_load();
    int wr_cycles, first_wr, bad;
    bit saw_step;
    wr_cycles = 0; first_wr = -1; saw_step = 0; bad = 0;
    rst_n = 1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL load_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
      if (wr_en === 1'b1) begin wr_cycles++; if (first_wr < 0) first_wr = k; end
      if (step === 1'b1) saw_step = 1;
    end
    n_checks++;
    if (first_wr != 1) $display("FAIL load_first_wr: got cycle %0d required 1", first_wr);
    else n_pass++;
    n_checks++;
    if (wr_cycles != 32) $display("FAIL load_wr_cycles: got %0d required 32", wr_cycles);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || saw_step) $display("FAIL load_done: busy=%b saw_step=%0d required 0 0", busy, saw_step);
    else n_pass++;
    for (int r = 0; r < ROWS; r++) if (wr_cnt[r] != 1) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL load_rows_once: %0d bad rows, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_period();
    int last, steps, bad_gap;
    last = -1; steps = 0; bad_gap = 0;
    period = 5; pause = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL period5_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
      if (step === 1'b1) begin
        if ((last < 0 && k != 5) || (last >= 0 && k - last != 5)) bad_gap++;
        last = k; steps++;
      end
    end
    n_checks++;
    if (steps != 6 || bad_gap != 0) $display("FAIL period5_steps: got %0d steps %0d bad gaps required 6 0", steps, bad_gap);
    else n_pass++;
    period = 0; steps = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL period0_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
      if (step === 1'b1) steps++;
    end
    n_checks++;
    if (steps != 0) $display("FAIL period0_steps: got %0d required 0", steps);
    else n_pass++;
  endtask

  task automatic test_pause();
    int steps, bad_pos, first_after;
    steps = 0; bad_pos = 0; first_after = -1;
    period = 5;
    repeat (2) tick();
    pause = 1;
    for (int k = 0; k < 10; k++) begin
      single_step = (k == 2 || k == 5);
      tick();
      single_step = 0;
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL pause_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
      if (step === 1'b1) steps++;
      if ((step === 1'b1) != (k == 2 || k == 5)) bad_pos++;
    end
    n_checks++;
    if (steps != 2 || bad_pos != 0) $display("FAIL pause_single_steps: got %0d steps %0d misplaced required 2 0", steps, bad_pos);
    else n_pass++;
    pause = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL unpause_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
      if (step === 1'b1 && first_after < 0) first_after = k;
    end
    // Two counts elapsed before the pause, so three more reach period 5.
    n_checks++;
    if (first_after != 3) $display("FAIL unpause_first_step: got cycle %0d required 3", first_after);
    else n_pass++;
  endtask

  task automatic test_en_drop();
    int k, bad, drop_bad;
    bad = 0; drop_bad = 0;
    pattern_sel = 3; load = 1;
    tick();
    load = 0;
    clear_wr_cnt();
    k = 0;
    while (k < 40 && !(wr_en === 1'b1 && row_select == 10)) begin
      tick(); k++;
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL endrop_pre_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (!(wr_en === 1'b1 && row_select == 10)) $display("FAIL endrop_reach_row10: row=%0d wr_en=%b after %0d cycles", row_select, wr_en, k);
    else n_pass++;
    en = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (wr_en !== 1'b0 || row_select != 10) drop_bad++;
    end
    n_checks++;
    if (drop_bad != 0) $display("FAIL endrop_frozen: %0d cycles with wr_en high or row moved, required 0", drop_bad);
    else n_pass++;
    en = 1;
    tick();
    n_checks++;
    if (wr_en !== 1'b1 || row_select != 10) $display("FAIL endrop_resume: wr_en=%b row=%0d required 1 10", wr_en, row_select);
    else n_pass++;
    k = 0;
    while (k < 40 && busy === 1'b1) begin
      tick(); k++;
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL endrop_post_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
    end
    for (int r = 0; r < ROWS; r++) if (wr_cnt[r] != 1) bad++;
    n_checks++;
    if (bad != 0 || busy !== 1'b0) $display("FAIL endrop_rows_once: %0d bad rows busy=%b required 0 0", bad, busy);
    else n_pass++;
  endtask

  task automatic test_load_restart();
    int k, bad;
    bad = 0;
    pattern_sel = 0; load = 1;
    tick();
    load = 0;
    k = 0;
    while (k < 40 && !(wr_en === 1'b1 && row_select == 20)) begin tick(); k++; end
    n_checks++;
    if (!(wr_en === 1'b1 && row_select == 20)) $display("FAIL restart_reach_row20: row=%0d wr_en=%b", row_select, wr_en);
    else n_pass++;
    pattern_sel = 2; load = 1;
    tick();
    load = 0;
    n_checks++;
    if (row_select !== '0 || wr_en !== 1'b0 || busy !== 1'b1 || cells !== 8'b0000_0001)
      $display("FAIL restart_row0: row=%0d wr_en=%b busy=%b cells=%b required 0 0 1 00000001",
               row_select, wr_en, busy, cells);
    else n_pass++;
    clear_wr_cnt();
    k = 0;
    while (k < 40 && busy === 1'b1) begin
      tick(); k++;
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL restart_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
    end
    for (int r = 0; r < ROWS; r++) if (wr_cnt[r] != 1) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL restart_rows_once: %0d bad rows required 0", bad);
    else n_pass++;
    // Load lands on the edge that would otherwise emit a step.
    period = 3; pause = 0;
    k = 0;
    while (k < 10 && !(m_since + 1 >= int'(period))) begin tick(); k++; end
    pattern_sel = 1; load = 1;
    tick();
    load = 0;
    n_checks++;
    if (step !== 1'b0 || busy !== 1'b1 || row_select !== '0)
      $display("FAIL load_vs_step: step=%b busy=%b row=%0d required 0 1 0", step, busy, row_select);
    else n_pass++;
  endtask

  task automatic test_reset_midload();
    int k, bad;
    bad = 0; k = 0;
    while (k < 40 && !(wr_en === 1'b1 && row_select == 15)) begin tick(); k++; end
    n_checks++;
    if (!(wr_en === 1'b1 && row_select == 15)) $display("FAIL rstmid_reach_row15: row=%0d wr_en=%b", row_select, wr_en);
    else n_pass++;
    rst_n = 0;
    tick();
    rst_n = 1;
    n_checks++;
    if (row_select !== '0 || wr_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL rstmid_abort: row=%0d wr_en=%b busy=%b required 0 0 1", row_select, wr_en, busy);
    else n_pass++;
    clear_wr_cnt();
    for (int j = 1; j <= 33; j++) begin
      tick();
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL rstmid_cyc%0d: got %h required %h", j, w_obs, exp_vec());
      else n_pass++;
    end
    for (int r = 0; r < ROWS; r++) if (wr_cnt[r] != 1) bad++;
    n_checks++;
    if (bad != 0 || busy !== 1'b0) $display("FAIL rstmid_reload: %0d bad rows busy=%b required 0 0", bad, busy);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      en          = ($urandom_range(0, 9) != 0);
      load        = ($urandom_range(0, 59) == 0);
      pattern_sel = PAT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) period = CNT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      single_step = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (w_obs !== exp_vec()) $display("FAIL random_cyc%0d: got %h required %h", k, w_obs, exp_vec());
      else n_pass++;
    end
    rst_n = 1; en = 1; load = 0; single_step = 0; pause = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load();
    test_period();
    test_pause();
    test_en_drop();
    test_load_restart();
    test_reset_midload();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
